// File: rtl/frame_sync_pkg.sv
// Shared types for the frame sync detector: FSM state encoding and lock decode.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    VERIFY   = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } fs_state_e;

  // Lock is held through the flywheel so one bad frame does not drop the link.
  function automatic logic is_locked(fs_state_e s);
    return (s == LOCKED) || (s == FLYWHEEL);
  endfunction

endpackage

// File: rtl/pattern_match.sv
// Masked pattern compare with an error tolerance: ok when the count of
// mismatching compared bits is within ERR_TOL.
module pattern_match #(
  parameter int PAT_W   = 7,
  parameter int ERR_TOL = 0
) (
  input  logic [PAT_W-1:0] data,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] mask,
  output logic             ok
);
  localparam int CW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] diff;
  logic [CW-1:0]    errs;

  assign diff = (data ^ pattern) & mask;

  always_comb begin
    errs = '0;
    for (int i = 0; i < PAT_W; i++) errs = errs + CW'(diff[i]);
  end

  assign ok = (errs <= CW'(ERR_TOL));

endmodule

// File: rtl/frame_sync_detector.sv
// Serial sync-word detector with frame flywheel and lock/unlock hysteresis.
module frame_sync_detector
  import frame_sync_pkg::*;
#(
  parameter int PAT_W       = 7,
  parameter int FRAME_LEN   = 16,
  parameter int LOCK_HITS   = 3,
  parameter int UNLOCK_MISS = 2,
  parameter int ERR_TOL     = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               din_valid,
  input  logic                               din,
  input  logic [PAT_W-1:0]                   pattern,
  input  logic [PAT_W-1:0]                   pat_mask,
  output logic                               hit,
  output logic                               lock,
  output logic [1:0]                         state,
  output logic [$clog2(FRAME_LEN)-1:0]       bit_pos,
  output logic [$clog2(LOCK_HITS+1)-1:0]     hit_cnt,
  output logic [$clog2(UNLOCK_MISS+1)-1:0]   miss_cnt
);
  localparam int FW  = $clog2(PAT_W + 1);
  localparam int BPW = $clog2(FRAME_LEN);
  localparam int HW  = $clog2(LOCK_HITS + 1);
  localparam int MW  = $clog2(UNLOCK_MISS + 1);

  logic [PAT_W-1:0] sh, sh_nx;
  logic [FW-1:0]    fill, fill_nx;
  fs_state_e        st, st_nx;
  logic [BPW-1:0]   bp_nx;
  logic [HW-1:0]    hc_nx;
  logic [MW-1:0]    mc_nx;
  logic             pm_ok, match, check, hit_nx;

  assign sh_nx   = {sh[PAT_W-2:0], din};
  assign fill_nx = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
  assign match   = pm_ok && (fill_nx == FW'(PAT_W));
  assign check   = (bit_pos == BPW'(FRAME_LEN - 1));
  assign state   = st;

  pattern_match #(.PAT_W(PAT_W), .ERR_TOL(ERR_TOL)) u_match (
    .data    (sh_nx),
    .pattern (pattern),
    .mask    (pat_mask),
    .ok      (pm_ok)
  );

  always_comb begin
    st_nx  = st;
    bp_nx  = bit_pos;
    hc_nx  = hit_cnt;
    mc_nx  = miss_cnt;
    hit_nx = 1'b0;
    if (din_valid) begin
      bp_nx = check ? '0 : bit_pos + BPW'(1);
      unique case (st)
        HUNT: begin
          bp_nx = '0;
          if (match) begin
            hit_nx = 1'b1;
            if (LOCK_HITS == 1) begin
              st_nx = LOCKED;
              hc_nx = '0;
            end else begin
              st_nx = VERIFY;
              hc_nx = HW'(1);
            end
          end
        end
        VERIFY: if (check) begin
          if (match) begin
            hit_nx = 1'b1;
            if (hit_cnt + HW'(1) == HW'(LOCK_HITS)) begin
              st_nx = LOCKED;
              hc_nx = '0;
            end else begin
              hc_nx = hit_cnt + HW'(1);
            end
          end else begin
            st_nx = HUNT;
            hc_nx = '0;
          end
        end
        LOCKED: if (check) begin
          if (match) begin
            hit_nx = 1'b1;
          end else if (UNLOCK_MISS == 1) begin
            st_nx = HUNT;
          end else begin
            st_nx = FLYWHEEL;
            mc_nx = MW'(1);
          end
        end
        FLYWHEEL: if (check) begin
          if (match) begin
            hit_nx = 1'b1;
            st_nx  = LOCKED;
            mc_nx  = '0;
          end else if (miss_cnt + MW'(1) == MW'(UNLOCK_MISS)) begin
            st_nx = HUNT;
            mc_nx = '0;
          end else begin
            mc_nx = miss_cnt + MW'(1);
          end
        end
      endcase
    end
  end

  // Shift history survives a drop to HUNT so the search resumes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      fill     <= '0;
      st       <= HUNT;
      bit_pos  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      hit      <= 1'b0;
      lock     <= 1'b0;
    end else begin
      hit <= hit_nx;
      if (din_valid) begin
        sh       <= sh_nx;
        fill     <= fill_nx;
        st       <= st_nx;
        bit_pos  <= bp_nx;
        hit_cnt  <= hc_nx;
        miss_cnt <= mc_nx;
        lock     <= is_locked(st_nx);
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_detector.sv
// Bench for frame_sync_detector: two builds (ERR_TOL 0 and 1) on shared stimulus,
// compared every cycle against a bit-history reference model.
module tb_frame_sync_detector;
  localparam int PAT_W = 7, FRAME_LEN = 16, LOCK_HITS = 3, UNLOCK_MISS = 2;

  logic clk, rst_n, din_valid, din;
  logic [PAT_W-1:0] pattern, pat_mask;
  logic hit0, lock0, hit1, lock1;
  logic [1:0] st0, st1, hc0, hc1, mc0, mc1;
  logic [3:0] bp0, bp1;

  frame_sync_detector dut0 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .pattern(pattern), .pat_mask(pat_mask), .hit(hit0), .lock(lock0),
    .state(st0), .bit_pos(bp0), .hit_cnt(hc0), .miss_cnt(mc0)
  );

  frame_sync_detector #(.ERR_TOL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .pattern(pattern), .pat_mask(pat_mask), .hit(hit1), .lock(lock1),
    .state(st1), .bit_pos(bp1), .hit_cnt(hc1), .miss_cnt(mc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int hits0 = 0;
  logic hist[$];
  int m_st[2], m_pos[2], m_hc[2], m_mc[2], m_hit[2];
  int tol[2] = '{0, 1};

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_err();
    int e = 0;
    for (int i = 0; i < PAT_W; i++)
      if (pat_mask[i] && hist[hist.size()-1-i] !== pattern[i]) e++;
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pos[k] = 0; m_hc[k] = 0; m_mc[k] = 0; m_hit[k] = 0;
    end
  endtask

  // One valid bit for instance k; mt says whether the last PAT_W bits are acceptable.
  task automatic model_step(int k, bit mt);
    bit at_check;
    m_hit[k] = 0;
    at_check = (m_st[k] == 0) || (m_pos[k] == FRAME_LEN - 1);
    m_pos[k] = (m_st[k] == 0) ? 0 : (m_pos[k] + 1) % FRAME_LEN;
    if (!at_check) return;
    case (m_st[k])
      0: if (mt) begin
        m_hit[k] = 1; m_pos[k] = 0; m_hc[k] = 1; m_st[k] = 1;
        if (LOCK_HITS == 1) begin m_st[k] = 2; m_hc[k] = 0; end
      end
      1: if (mt) begin
        m_hit[k] = 1; m_hc[k]++;
        if (m_hc[k] == LOCK_HITS) begin m_st[k] = 2; m_hc[k] = 0; end
      end else begin
        m_st[k] = 0; m_hc[k] = 0;
      end
      2: if (mt) m_hit[k] = 1;
      else begin
        m_mc[k] = 1; m_st[k] = 3;
        if (m_mc[k] == UNLOCK_MISS) begin m_st[k] = 0; m_mc[k] = 0; end
      end
      default: if (mt) begin
        m_hit[k] = 1; m_st[k] = 2; m_mc[k] = 0;
      end else begin
        m_mc[k]++;
        if (m_mc[k] == UNLOCK_MISS) begin m_st[k] = 0; m_mc[k] = 0; end
      end
    endcase
  endtask

  task automatic check_all();
    chk("hit0", int'(hit0), m_hit[0]);
    chk("lock0", int'(lock0), int'(m_st[0] >= 2));
    chk("state0", int'(st0), m_st[0]);
    chk("bit_pos0", int'(bp0), m_pos[0]);
    chk("hit_cnt0", int'(hc0), m_hc[0]);
    chk("miss_cnt0", int'(mc0), m_mc[0]);
    chk("hit1", int'(hit1), m_hit[1]);
    chk("lock1", int'(lock1), int'(m_st[1] >= 2));
    chk("state1", int'(st1), m_st[1]);
    chk("bit_pos1", int'(bp1), m_pos[1]);
    chk("hit_cnt1", int'(hc1), m_hc[1]);
    chk("miss_cnt1", int'(mc1), m_mc[1]);
  endtask

  task automatic tick(logic v, logic d);
    din_valid = v;
    din = d;
    @(posedge clk);
    if (rst_n) begin
      if (v) begin
        hist.push_back(d);
        if (hist.size() > PAT_W) void'(hist.pop_front());
      end
      for (int k = 0; k < 2; k++) begin
        if (v) model_step(k, (hist.size() == PAT_W) && (n_err() <= tol[k]));
        else m_hit[k] = 0;
      end
    end
    #1;
    check_all();
    if (hit0) hits0++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    din = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick(1'b1, 1'($urandom));
    rst_n = 1'b1;
    hits0 = 0;
  endtask

  task automatic send_bits(logic [PAT_W-1:0] p, bit gaps);
    for (int i = PAT_W - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 5) == 0) repeat (3) tick(1'b0, 1'($urandom));
      tick(1'b1, p[i]);
    end
  endtask

  task automatic send_frame(logic [PAT_W-1:0] p, bit gaps);
    send_bits(p, gaps);
    for (int i = 0; i < FRAME_LEN - PAT_W; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) repeat (3) tick(1'b0, 1'($urandom));
      tick(1'b1, 1'b0);
    end
  endtask

  localparam logic [PAT_W-1:0] SYNC = 7'b1001001;
  localparam logic [PAT_W-1:0] BAD  = 7'b1011001;

  initial begin
    logic [PAT_W-1:0] p;
    int h;
    pattern = SYNC;
    pat_mask = '1;
    do_reset();

    // Partial fill must never match.
    for (int i = PAT_W - 1; i >= 1; i--) tick(1'b1, SYNC[i]);
    chk("fill_no_hit", hits0, 0);

    do_reset();
    repeat (3) send_frame(SYNC, 1'b0);
    chk("acq_hits", hits0, 3);
    chk("acq_state", int'(st0), 2);
    chk("acq_lock", int'(lock0), 1);

    send_frame(BAD, 1'b0);
    chk("hyst_state", int'(st0), 3);
    chk("hyst_lock", int'(lock0), 1);
    chk("hyst_miss", int'(mc0), 1);
    send_frame(SYNC, 1'b0);
    chk("hyst_relock", int'(st0), 2);
    chk("hyst_miss0", int'(mc0), 0);

    send_frame(BAD, 1'b0);
    chk("loss_fly", int'(st0), 3);
    send_frame(BAD, 1'b0);
    chk("loss_state", int'(st0), 0);
    chk("loss_lock", int'(lock0), 0);
    h = hits0;
    send_frame(SYNC, 1'b0);
    chk("reacq_hit", hits0 - h, 1);
    chk("reacq_state", int'(st0), 1);

    do_reset();
    repeat (3) send_frame(SYNC, 1'b1);
    chk("gap_hits", hits0, 3);
    chk("gap_state", int'(st0), 2);

    // Asynchronous reset while locked, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lock0", int'(lock0), 0);
    chk("arst_lock1", int'(lock1), 0);
    chk("arst_state0", int'(st0), 0);
    do_reset();

    // Tolerance build: one flip accepted, two rejected, masked flip ignored.
    send_bits(SYNC ^ 7'b0000100, 1'b0);
    chk("tol_one_flip", int'(hit1), 1);
    chk("tol0_one_flip", int'(hit0), 0);
    do_reset();
    send_bits(SYNC ^ 7'b0100010, 1'b0);
    chk("tol_two_flip", int'(hit1), 0);
    do_reset();
    pat_mask = 7'b1110111;
    send_bits(SYNC ^ 7'b0001001, 1'b0);
    chk("tol_masked_flip", int'(hit1), 1);

    // Random soak: frames with random corruption, gaps and occasional pattern changes.
    do_reset();
    for (int f = 0; f < 160; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        pattern = PAT_W'($urandom);
        pat_mask = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom) : '1;
      end
      p = pattern;
      if ($urandom_range(0, 3) == 0) p[$urandom_range(0, PAT_W-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) p[$urandom_range(0, PAT_W-1)] ^= 1'b1;
      send_bits(p, 1'b1);
      for (int i = 0; i < FRAME_LEN - PAT_W; i++) begin
        if ($urandom_range(0, 9) == 0) tick(1'b0, 1'($urandom));
        tick(1'b1, ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sync_detector.md
Name: frame_sync_detector

Overview:
Parametrised serial pattern detector with frame-synchronisation and lock hysteresis. It generalises the fixed single-pattern bit-stream FSM to a runtime-programmable, maskable pattern of width PAT_W with an error tolerance. After the first match it expects the pattern once every FRAME_LEN valid bits. It declares lock after LOCK_HITS consecutive hits and drops lock after UNLOCK_MISS consecutive misses. It sits after a serial receive front end and feeds framing/deframing logic.

Parameters:
PAT_W, 7, sync pattern width in bits (>=2)
FRAME_LEN, 16, valid bits from one pattern end to the next expected end (>=PAT_W)
LOCK_HITS, 3, consecutive hits (first one included) needed to assert lock (>=1)
UNLOCK_MISS, 2, consecutive misses that drop lock (>=1)
ERR_TOL, 0, maximum mismatching unmasked bits still counted as a hit (<PAT_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
din_valid  in  1  din is sampled only when high
din  in  1  serial data, MSB of pattern first
pattern  in  PAT_W  expected pattern; pattern[PAT_W-1] is the first bit received
pat_mask  in  PAT_W  1 = compare this bit, 0 = don't care
hit  out  1  one-cycle pulse: the last sampled bit completed an accepted match
lock  out  1  frame lock indicator
state  out  2  0 HUNT, 1 VERIFY, 2 LOCKED, 3 FLYWHEEL
bit_pos  out  $clog2(FRAME_LEN)  valid-bit position within the frame
hit_cnt  out  $clog2(LOCK_HITS+1)  consecutive hits while in VERIFY
miss_cnt  out  $clog2(UNLOCK_MISS+1)  consecutive misses while locked

Behaviour:
- Reset (async assert, sync release): all outputs, the shift register and the fill counter are 0; state = HUNT.
- Shift: on clk edge with din_valid=1, sh <= {sh[PAT_W-2:0], din}. A fill counter saturates at PAT_W, so no match is possible before PAT_W valid bits have been received since reset.
- Match (combinational, on next sh): popcount((sh_next ^ pattern) & pat_mask) <= ERR_TOL, and the fill is complete. pat_mask=0 matches every bit once filled.
- All outputs are registered. hit, state, counters and lock update on the same edge that samples the completing bit, visible one cycle after din is presented.
- din_valid=0: no state, counter, bit_pos or hit change; hit=0 that cycle.
- bit_pos:
  - Held at 0 in HUNT.
  - Otherwise increments on each valid bit and wraps FRAME_LEN-1 -> 0.
  - A "check" occurs on the valid bit taken when bit_pos==FRAME_LEN-1.
- HUNT: every valid bit is a check.
  - Match -> hit=1, bit_pos=0, hit_cnt=1.
  - Next state is VERIFY, or LOCKED directly if LOCK_HITS==1.
- VERIFY: only checks count.
  - Match -> hit_cnt++; on reaching LOCK_HITS -> LOCKED (hit_cnt=0).
  - Mismatch -> HUNT, hit_cnt=0.
- LOCKED: check match -> stay, hit=1. Mismatch -> miss_cnt=1, then FLYWHEEL, or HUNT if UNLOCK_MISS==1.
- FLYWHEEL:
  - Match -> LOCKED, miss_cnt=0, hit=1.
  - Mismatch -> miss_cnt++; on reaching UNLOCK_MISS -> HUNT with miss_cnt=0.
- lock = 1 in LOCKED and FLYWHEEL, 0 otherwise.
- Entering HUNT keeps sh and fill, so the search resumes on the next valid bit. The failing bit itself is not re-evaluated as a HUNT match.
- hit is 1 only on accepted matches: any match in HUNT, check matches elsewhere.
- pattern/pat_mask are sampled at each comparison. Changing them while locked is legal and takes effect at the next check.
- Async reset mid-frame: all outputs drop to 0 immediately, with no partial-state retention.

Decomposition:
- Package frame_sync_pkg holds the state enum (HUNT, VERIFY, LOCKED, FLYWHEEL) as a 2-bit typedef.
- One sub-module, pattern_match: purely combinational masked XOR, popcount and ERR_TOL compare, parametrised by PAT_W and ERR_TOL.
- The top holds the shift register, fill counter, bit_pos, counters and FSM.

Test Plan:
- Hold rst_n=0 -> hit=0, lock=0, state=0, bit_pos=0, counters 0. Release rst_n, drive 6 valid bits equal to pattern[6:1] -> no hit (fill incomplete).
- Lock acquisition (defaults, pattern=1001001, pat_mask all ones): send 1001001 followed by 9 zeros, three times contiguously -> hit pulses on valid bits 7, 23 and 39; state 1 after bit 7; state 2 and lock=1 after bit 39.
- Hysteresis: once locked, corrupt one pattern (1011001) -> no hit, state 3, lock stays 1, miss_cnt=1. Next frame correct -> state 2, miss_cnt=0.
- Loss of lock: once locked, corrupt two consecutive frames -> state 3 then 0, lock falls after the second bad check. A following clean pattern -> hit and state 1.
- din_valid gaps: repeat the acquisition scenario with din_valid=0 for 3 cycles inserted at random points -> identical hit/state sequence in valid-bit time, no output change during the gaps.
- ERR_TOL=1 build: a pattern with one flipped bit -> hit. Two flipped bits -> miss. With pat_mask=1110111, two flips where one is in bit 3 -> hit. Async reset asserted in LOCKED -> lock=0 with no clock edge.
